nrs_cinit_scheduler: RTL and testbench

Sequencing controller for the NRS value generator in the NB-IoT transmit chain. Per radio frame it latches N_cell_ID and walks the NRS-bearing symbols: slots 0..19, skipping slots 10/11 (subframe 5), with l=5,6 in each slot. For each symbol it computes the Gold-sequence c_init, starts the generator and waits for completion. After the 4 symbols of a subframe it presents them to the resource mapper and holds until the mapper releases the buffer.

---
 rtl/nrs_cinit_scheduler_if.sv | 34 +++
 rtl/nrs_cinit_scheduler.sv | 176 +++++++++++++++++
 tb/tb_nrs_cinit_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrs_cinit_scheduler_if.sv
// Handshake bundle between the NRS c_init scheduler, the Gold-sequence generator
// and the resource mapper.
interface nrs_cinit_scheduler_if #(
    parameter int unsigned WIDTH_B = 9,
    parameter int unsigned CINIT_W = 28
);
    logic               new_frame;
    logic [WIDTH_B-1:0] N_cell_ID;
    logic               new_subframe;
    logic               gen_done;
    logic               gen_start;
    logic [CINIT_W-1:0] gen_cinit;
    logic [1:0]         gen_sym_idx;
    logic               sf_ready;
    logic [3:0]         sf_num;
    logic [4:0]         ns_out;
    logic               busy;
    logic               frame_done;
    logic               err;

    // Scheduler side
    modport master (
        input  new_frame, N_cell_ID, new_subframe, gen_done,
        output gen_start, gen_cinit, gen_sym_idx, sf_ready, sf_num, ns_out,
               busy, frame_done, err
    );

    // Generator / mapper / frame-timing side
    modport slave (
        output new_frame, N_cell_ID, new_subframe, gen_done,
        input  gen_start, gen_cinit, gen_sym_idx, sf_ready, sf_num, ns_out,
               busy, frame_done, err
    );
endinterface

// File: rtl/nrs_cinit_scheduler.sv
// Per-frame NRS symbol sequencer: computes the Gold c_init for each NRS symbol
// (slots 0..19 minus subframe 5, l=5,6), runs the generator and hands subframes to the mapper.
module nrs_cinit_scheduler #(
    parameter int unsigned WIDTH_B = 9,
    parameter int unsigned CINIT_W = 28,
    parameter int unsigned SKIP_SF = 5,
    parameter int unsigned NUM_SF  = 10,
    parameter int unsigned TIMEOUT = 2047
) (
    input logic                   clk,
    input logic                   rst,
    nrs_cinit_scheduler_if.master bus
);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned MAX_ID = 503;
    localparam int unsigned MUL_W  = 8;

    typedef enum logic [2:0] {IDLE, CALC, START, WAIT, READY} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_B-1:0] id_q, id_d;
    logic [3:0]         sf_q, sf_d;
    logic [4:0]         ns_q, ns_d;
    logic [2:0]         l_q, l_d;
    logic [1:0]         sym_q, sym_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               sf_ready_q, sf_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               gen_start_q, gen_start_d;
    logic               busy_q, busy_d;
    logic [CINIT_W-1:0] cinit_q, cinit_d;

    logic [MUL_W-1:0]   mul_a;
    logic [WIDTH_B:0]   mul_b;
    logic [CINIT_W-1:0] cinit_calc;
    logic [3:0]         sf_inc;

    // c_init = (7*(ns+1)+l+1)*(2*id+1)*2^10 + 2*id+1
    always_comb begin
        mul_a      = MUL_W'(7) * MUL_W'(ns_q) + MUL_W'(l_q) + MUL_W'(8);
        mul_b      = {id_q, 1'b1};
        cinit_calc = ((CINIT_W'(mul_a) * CINIT_W'(mul_b)) << 10) + CINIT_W'(mul_b);
    end

    // Next subframe index, stepping over the subframe that carries no NRS
    always_comb begin
        sf_inc = sf_q + 4'd1;
        if (sf_inc == 4'(SKIP_SF)) sf_inc = sf_q + 4'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            sf_q         <= '0;
            ns_q         <= '0;
            l_q          <= '0;
            sym_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            sf_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            gen_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            cinit_q      <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            sf_q         <= sf_d;
            ns_q         <= ns_d;
            l_q          <= l_d;
            sym_q        <= sym_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            sf_ready_q   <= sf_ready_d;
            frame_done_q <= frame_done_d;
            gen_start_q  <= gen_start_d;
            busy_q       <= busy_d;
            cinit_q      <= cinit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        sf_d         = sf_q;
        ns_d         = ns_q;
        l_d          = l_q;
        sym_d        = sym_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        sf_ready_d   = sf_ready_q;
        frame_done_d = 1'b0;
        cinit_d      = cinit_q;

        // A frame start overrides whatever is in flight, including same-cycle handshakes
        if (bus.new_frame) begin
            sf_ready_d = 1'b0;
            if (bus.N_cell_ID <= WIDTH_B'(MAX_ID)) begin
                id_d    = bus.N_cell_ID;
                sf_d    = '0;
                ns_d    = '0;
                l_d     = 3'd5;
                sym_d   = '0;
                err_d   = 1'b0;
                state_d = CALC;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                CALC: begin
                    cinit_d = cinit_calc;
                    state_d = START;
                end
                START: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.gen_done) begin
                        if (sym_q != 2'd3) begin
                            sym_d = sym_q + 2'd1;
                            if (l_q == 3'd5) begin
                                l_d = 3'd6;
                            end else begin
                                l_d  = 3'd5;
                                ns_d = ns_q + 5'd1;
                            end
                            state_d = CALC;
                        end else begin
                            sf_ready_d = 1'b1;
                            state_d    = READY;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                READY: begin
                    if (bus.new_subframe) begin
                        sf_ready_d = 1'b0;
                        sym_d      = '0;
                        if (sf_q == 4'(NUM_SF - 1)) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            sf_d    = sf_inc;
                            ns_d    = {sf_inc, 1'b0};
                            l_d     = 3'd5;
                            state_d = CALC;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        gen_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    assign bus.gen_start   = gen_start_q;
    assign bus.gen_cinit   = cinit_q;
    assign bus.gen_sym_idx = sym_q;
    assign bus.sf_ready    = sf_ready_q;
    assign bus.sf_num      = sf_q;
    assign bus.ns_out      = ns_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_nrs_cinit_scheduler.sv
// Directed bench for nrs_cinit_scheduler: generator and mapper are played by tasks,
// expected c_init values come from the closed-form formula.
module tb_nrs_cinit_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nrs_cinit_scheduler_if #(.WIDTH_B(9), .CINIT_W(28)) bus ();

    nrs_cinit_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    always @(posedge clk) if (bus.gen_start === 1'b1) start_cnt++;

    function automatic logic [43:0] outs();
        return {bus.gen_start, bus.gen_cinit, bus.gen_sym_idx, bus.sf_ready, bus.sf_num,
                bus.ns_out, bus.busy, bus.frame_done, bus.err};
    endfunction

    function automatic logic [27:0] exp_cinit(input int id, input int ns, input int l);
        int unsigned v;
        v = (7 * (ns + 1) + l + 1) * (2 * id + 1) * 1024 + 2 * id + 1;
        return 28'(v);
    endfunction

    task automatic pulse_frame(input int id);
        @(negedge clk);
        bus.N_cell_ID = 9'(id);
        bus.new_frame = 1'b1;
        @(negedge clk);
        bus.new_frame = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.gen_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
    endtask

    task automatic release_sf();
        @(negedge clk);
        bus.new_subframe = 1'b1;
        @(negedge clk);
        bus.new_subframe = 1'b0;
    endtask

    task automatic run_sym(output int n, output logic [27:0] c, output logic [4:0] ns,
                           output logic [1:0] si);
        wait_start(n);
        c  = bus.gen_cinit;
        ns = bus.ns_out;
        si = bus.gen_sym_idx;
        if (n > 0) pulse_done();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.new_frame = 1'b0;
        bus.N_cell_ID = '0;
        bus.new_subframe = 1'b0;
        bus.gen_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (outs() !== 44'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_first_subframe();
        logic [27:0] exp[4] = '{28'd13313, 28'd14337, 28'd20481, 28'd21505};
        int n, s0;
        logic [27:0] c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(0);
        total++;
        if (bus.gen_start !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL calc_cycle: got start=%0b busy=%0b expected start=0 busy=1",
                     bus.gen_start, bus.busy);
        end
        for (int k = 0; k < 4; k++) begin
            run_sym(n, c, ns, si);
            total++;
            if (n !== 1) begin
                bad++;
                $display("FAIL start_latency%0d: got %0d expected 1", k, n);
            end
            total++;
            if (c !== exp[k] || si !== 2'(k) || ns !== 5'(k >> 1)) begin
                bad++;
                $display("FAIL id0_sym%0d: got cinit=%0d idx=%0d ns=%0d expected %0d %0d %0d",
                         k, c, si, ns, exp[k], k, k >> 1);
            end
        end
        total++;
        if (bus.sf_ready !== 1'b1 || bus.sf_num !== 4'd0 || bus.ns_out !== 5'd1) begin
            bad++;
            $display("FAIL sf0_ready: got rdy=%0b sf=%0d ns=%0d expected 1 0 1",
                     bus.sf_ready, bus.sf_num, bus.ns_out);
        end
        s0 = start_cnt;
        pulse_done();
        repeat (5) @(negedge clk);
        total++;
        if (start_cnt !== s0 || bus.sf_ready !== 1'b1 || bus.gen_sym_idx !== 2'd3) begin
            bad++;
            $display("FAIL hold_ready: got starts=%0d rdy=%0b idx=%0d expected %0d 1 3",
                     start_cnt - s0 + s0, bus.sf_ready, bus.gen_sym_idx, s0);
        end
    endtask

    task automatic test_id1();
        int n;
        logic [27:0] c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(1);
        run_sym(n, c, ns, si);
        total++;
        if (c !== 28'd39939) begin
            bad++;
            $display("FAIL id1_cinit: got %0d expected 39939", c);
        end
    endtask

    task automatic test_full_frame();
        int sfl[9] = '{0, 1, 2, 3, 4, 6, 7, 8, 9};
        int n, s0, ready_seen;
        logic [27:0] c, last_c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(503);
        s0 = start_cnt;
        ready_seen = 0;
        last_c = '0;
        for (int j = 0; j < 9; j++) begin
            for (int k = 0; k < 4; k++) begin
                run_sym(n, c, ns, si);
                last_c = c;
                total++;
                if (n < 0 || c !== exp_cinit(503, 2 * sfl[j] + (k >> 1), 5 + (k & 1)) ||
                    ns !== 5'(2 * sfl[j] + (k >> 1))) begin
                    bad++;
                    $display("FAIL frame_sf%0d_sym%0d: got n=%0d cinit=%0d ns=%0d expected %0d ns=%0d",
                             sfl[j], k, n, c, exp_cinit(503, 2 * sfl[j] + (k >> 1), 5 + (k & 1)),
                             ns, 2 * sfl[j] + (k >> 1));
                end
            end
            if (bus.sf_ready === 1'b1) ready_seen++;
            total++;
            if (bus.sf_ready !== 1'b1 || bus.sf_num !== 4'(sfl[j])) begin
                bad++;
                $display("FAIL frame_ready%0d: got rdy=%0b sf=%0d expected 1 %0d",
                         j, bus.sf_ready, bus.sf_num, sfl[j]);
            end
            release_sf();
            if (j < 8) begin
                total++;
                if (bus.sf_ready !== 1'b0 || bus.frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL release%0d: got rdy=%0b done=%0b expected 0 0",
                             j, bus.sf_ready, bus.frame_done);
                end
            end
        end
        total++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_done: got done=%0b busy=%0b expected 1 0",
                     bus.frame_done, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_pulse: got %0b expected 0", bus.frame_done);
        end
        total++;
        if (last_c !== 28'd151582703) begin
            bad++;
            $display("FAIL last_cinit: got %0d expected 151582703", last_c);
        end
        total++;
        if (start_cnt - s0 !== 36 || ready_seen !== 9) begin
            bad++;
            $display("FAIL frame_counts: got starts=%0d readies=%0d expected 36 9",
                     start_cnt - s0, ready_seen);
        end
    endtask

    task automatic test_preempt();
        int n;
        logic [27:0] c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(2);
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 4; k++) run_sym(n, c, ns, si);
            release_sf();
        end
        wait_start(n);
        total++;
        if (n < 0 || bus.sf_num !== 4'd3) begin
            bad++;
            $display("FAIL preempt_setup: got n=%0d sf=%0d expected sf=3", n, bus.sf_num);
        end
        @(negedge clk);
        bus.gen_done = 1'b1;
        bus.N_cell_ID = 9'd7;
        bus.new_frame = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
        bus.new_frame = 1'b0;
        total++;
        if (bus.sf_ready !== 1'b0 || bus.sf_num !== 4'd0 || bus.gen_sym_idx !== 2'd0 ||
            bus.ns_out !== 5'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL preempt_state: got rdy=%0b sf=%0d idx=%0d ns=%0d busy=%0b expected 0 0 0 0 1",
                     bus.sf_ready, bus.sf_num, bus.gen_sym_idx, bus.ns_out, bus.busy);
        end
        run_sym(n, c, ns, si);
        total++;
        if (n !== 1 || c !== 28'd199695) begin
            bad++;
            $display("FAIL preempt_cinit: got n=%0d cinit=%0d expected 1 199695", n, c);
        end
    endtask

    task automatic test_timeout();
        int n, cyc, s0;
        logic [27:0] c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(5);
        wait_start(n);
        cyc = -1;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge clk);
            if (bus.err === 1'b1) begin
                cyc = i;
                break;
            end
        end
        total++;
        if (cyc < 2040 || cyc > 2060 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout: got cycles=%0d busy=%0b expected ~2049 busy=0", cyc, bus.busy);
        end
        pulse_frame(9);
        total++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL err_clear: got err=%0b busy=%0b expected 0 1", bus.err, bus.busy);
        end
        run_sym(n, c, ns, si);
        total++;
        if (c !== 28'd252947) begin
            bad++;
            $display("FAIL id9_cinit: got %0d expected 252947", c);
        end
        pulse_frame(504);
        s0 = start_cnt;
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_id: got err=%0b busy=%0b expected 1 0", bus.err, bus.busy);
        end
        repeat (4) @(negedge clk);
        total++;
        if (start_cnt !== s0 || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL bad_id_idle: got starts=%0d err=%0b expected %0d 1",
                     start_cnt, bus.err, s0);
        end
        pulse_frame(9);
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear2: got %0b expected 0", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [27:0] c;
        logic [4:0] ns;
        logic [1:0] si;
        pulse_frame(3);
        run_sym(n, c, ns, si);
        run_sym(n, c, ns, si);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (outs() !== 44'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h expected 0", outs());
        end
        rst = 1'b0;
        pulse_frame(0);
        run_sym(n, c, ns, si);
        total++;
        if (n !== 1 || c !== 28'd13313 || si !== 2'd0) begin
            bad++;
            $display("FAIL restart: got n=%0d cinit=%0d idx=%0d expected 1 13313 0", n, c, si);
        end
    endtask

    initial begin
        test_reset();
        test_first_subframe();
        test_id1();
        test_full_frame();
        test_preempt();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
